// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped device bus: region map, arbiter
// states and the latched access payload.
package mmio_pkg;

    localparam int unsigned N_MST      = 2;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MASK_W     = 4;
    localparam int unsigned REGION_LSB = 20;
    localparam int unsigned REGION_W   = 4;
    localparam int unsigned CNT_W      = 2;

    localparam logic [REGION_W-1:0] ID_DMEM   = 4'h1;
    localparam logic [REGION_W-1:0] ID_SEG    = 4'h2;
    localparam logic [REGION_W-1:0] ID_TIMER  = 4'h3;
    localparam logic [REGION_W-1:0] ID_CMEM   = 4'h4;
    localparam logic [REGION_W-1:0] ID_KBD    = 4'h5;
    localparam logic [REGION_W-1:0] ID_SW     = 4'h6;
    localparam logic [REGION_W-1:0] ID_LED    = 4'h7;
    localparam logic [REGION_W-1:0] ID_VGA    = 4'h8;
    localparam logic [REGION_W-1:0] ID_SERIAL = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    // Access captured at grant and replayed onto the device bus
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } mmio_req_t;

    function automatic logic is_mapped(logic [REGION_W-1:0] id);
        logic hit;
        case (id)
            ID_DMEM, ID_SEG, ID_TIMER, ID_CMEM, ID_KBD,
            ID_SW, ID_LED, ID_VGA, ID_SERIAL: hit = 1'b1;
            default:                          hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Clamp a latency parameter into the wait counter range
    function automatic logic [CNT_W-1:0] sat_lat(int unsigned lat);
        logic [CNT_W-1:0] val;
        if (lat >= (1 << CNT_W)) begin
            val = {CNT_W{1'b1}};
        end else begin
            val = CNT_W'(lat);
        end
        return val;
    endfunction

endpackage

// File: rtl/mmio_arbiter_if.sv
// Master-side request/response signals plus the shared device bus, with the
// arbiter on the slave modport and the masters/decoder on the master modport.
interface mmio_arbiter_if;
    import mmio_pkg::*;

    logic [N_MST-1:0]             m_req;
    logic [N_MST-1:0]             m_we;
    logic [N_MST-1:0][ADDR_W-1:0] m_addr;
    logic [N_MST-1:0][DATA_W-1:0] m_wdata;
    logic [N_MST-1:0][MASK_W-1:0] m_wmask;
    logic [N_MST-1:0]             m_ready;
    logic [N_MST-1:0]             m_err;
    logic [DATA_W-1:0]            m_rdata;

    logic                         bus_valid;
    logic                         bus_we;
    logic                         bus_re;
    logic [ADDR_W-1:0]            bus_addr;
    logic [DATA_W-1:0]            bus_wdata;
    logic [MASK_W-1:0]            bus_wmask;
    logic [DATA_W-1:0]            bus_rdata;

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_wmask, bus_rdata,
        output m_ready, m_err, m_rdata,
        output bus_valid, bus_we, bus_re, bus_addr, bus_wdata, bus_wmask
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata, m_wmask, bus_rdata,
        input  m_ready, m_err, m_rdata,
        input  bus_valid, bus_we, bus_re, bus_addr, bus_wdata, bus_wmask
    );

endinterface

// File: rtl/mmio_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// master that was not served last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mmio_arbiter.sv
// Two-master arbiter and access sequencer for the device bus: round-robin
// grant, per-region read wait states, error completion for unmapped regions.
module mmio_arbiter
    import mmio_pkg::*;
#(
    parameter int unsigned DMEM_RD_LAT = 1,
    parameter int unsigned IO_RD_LAT   = 0
) (
    input logic           clk,
    input logic           rstn,
    mmio_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] DMEM_LAT = sat_lat(DMEM_RD_LAT);
    localparam logic [CNT_W-1:0] IO_LAT   = sat_lat(IO_RD_LAT);

    arb_state_t           state_q, state_d;
    logic                 last_q, last_d;
    logic                 gidx_q, gidx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    mmio_req_t            req_q, req_d;

    logic [N_MST-1:0]     ready_q, ready_d;
    logic [N_MST-1:0]     err_q, err_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 valid_q, valid_d;
    logic                 we_q, we_d;
    logic                 re_q, re_d;

    logic [N_MST-1:0]     gnt_c;
    logic                 gsel_c;
    mmio_req_t            cand_c;
    logic [REGION_W-1:0]  region_c;

    rr_pick2 u_pick (
        .req  (bus.m_req),
        .last (last_q),
        .gnt  (gnt_c)
    );

    // Candidate access from whichever master the selector picked
    always_comb begin
        gsel_c       = gnt_c[1];
        cand_c.we    = bus.m_we[gsel_c];
        cand_c.addr  = bus.m_addr[gsel_c];
        cand_c.wdata = bus.m_wdata[gsel_c];
        cand_c.wmask = bus.m_wmask[gsel_c];
        region_c     = cand_c.addr[REGION_LSB +: REGION_W];
    end

    // Next state and next registered outputs; strobes only on IDLE->ACCESS
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gidx_d  = gidx_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        ready_d = '0;
        err_d   = '0;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        we_d    = 1'b0;
        re_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|bus.m_req) begin
                    gidx_d = gsel_c;
                    last_d = gsel_c;
                    req_d  = cand_c;
                    cnt_d  = (region_c == ID_DMEM) ? DMEM_LAT : IO_LAT;
                    if (is_mapped(region_c)) begin
                        state_d = ACCESS;
                        valid_d = 1'b1;
                        we_d    = cand_c.we;
                        re_d    = !cand_c.we;
                    end else begin
                        state_d         = RESP;
                        ready_d[gsel_c] = 1'b1;
                        err_d[gsel_c]   = 1'b1;
                        rdata_d         = '0;
                    end
                end
            end

            ACCESS: begin
                if (req_q.we || (cnt_q == '0)) begin
                    state_d         = RESP;
                    ready_d[gidx_q] = 1'b1;
                    if (!req_q.we) begin
                        rdata_d = bus.bus_rdata;
                    end
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    valid_d = 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gidx_q  <= 1'b0;
            cnt_q   <= '0;
            req_q   <= '0;
            ready_q <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            re_q    <= re_d;
        end
    end

    assign bus.m_ready   = ready_q;
    assign bus.m_err     = err_q;
    assign bus.m_rdata   = rdata_q;
    assign bus.bus_valid = valid_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_re    = re_q;
    assign bus.bus_addr  = req_q.addr;
    assign bus.bus_wdata = req_q.wdata;
    assign bus.bus_wmask = req_q.wmask;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter: per-cycle vector table on the default
// instance plus sequences for contention, reset mid-read and read latency.
module tb_mmio_arbiter;

    localparam logic [31:0] WD0  = 32'hA0A0_0001;
    localparam logic [31:0] WD1  = 32'hB1B1_0002;
    localparam logic [3:0]  WM0  = 4'hF;
    localparam logic [3:0]  WM1  = 4'h3;
    localparam logic [31:0] A_RD = 32'h0010_0004;
    localparam logic [31:0] A_UN = 32'h00A0_0000;
    localparam logic [31:0] A_LD = 32'h0070_0000;
    localparam logic [31:0] A_SG = 32'h0020_0000;

    typedef struct {
        logic        rstn;
        logic [1:0]  req;
        logic [1:0]  we;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] rd;
        logic [1:0]  e_ready;
        logic [1:0]  e_err;
        logic        e_valid;
        logic        e_we;
        logic        e_re;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wmask;
        logic [31:0] e_rdata;
    } vec_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   tests = 0;
    int   fails = 0;

    mmio_arbiter_if bus ();
    mmio_arbiter_if bus2 ();

    mmio_arbiter u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    mmio_arbiter #(.DMEM_RD_LAT(2)) u_dut2 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rs, input logic [1:0] rq, input logic [1:0] w,
        input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] rd,
        input logic [1:0] erdy, input logic [1:0] eerr, input logic ev,
        input logic ewe, input logic ere, input logic [31:0] eaddr,
        input logic [31:0] ewd, input logic [3:0] ewm, input logic [31:0] erdata);
        vec_t v;
        v.rstn = rs;     v.req = rq;       v.we = w;
        v.a0 = a0;       v.a1 = a1;        v.rd = rd;
        v.e_ready = erdy; v.e_err = eerr;  v.e_valid = ev;
        v.e_we = ewe;    v.e_re = ere;     v.e_addr = eaddr;
        v.e_wdata = ewd; v.e_wmask = ewm;  v.e_rdata = erdata;
        return v;
    endfunction

    // Request must stay stable until the cycle its m_ready is seen
    logic [1:0]       p_req = '0;
    logic [1:0]       p_rdy = '0;
    logic [1:0]       p_we  = '0;
    logic [1:0][31:0] p_addr = '0;
    logic             p_rstn = 1'b0;

    always @(negedge clk) begin
        if (rstn && p_rstn) begin
            for (int m = 0; m < 2; m++) begin
                if (p_req[m] && !p_rdy[m] && !bus.m_ready[m] &&
                    (!bus.m_req[m] || bus.m_we[m] !== p_we[m] || bus.m_addr[m] !== p_addr[m])) begin
                    fails++;
                    $display("FAIL protocol m%0d: request changed before m_ready", m);
                end
            end
        end
        p_req  = bus.m_req;
        p_rdy  = bus.m_ready;
        p_we   = bus.m_we;
        p_addr = bus.m_addr;
        p_rstn = rstn;
    end

    // One access on the DMEM_RD_LAT=2 instance; bus_rdata is 0x100+cycle index
    task automatic run2(input int m, input logic w, input logic [31:0] addr, input string tag,
                        input int exp_lat, input int exp_acc, input logic [31:0] exp_rd);
        int          lat = 0;
        int          nval = 0;
        int          nstb = 0;
        logic [31:0] rd = '0;
        bus2.m_we[m]   = w;
        bus2.m_addr[m] = addr;
        bus2.m_req[m]  = 1'b1;
        bus2.bus_rdata = 32'h100;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            step();
            bus2.bus_rdata = 32'h100 + 32'(k);
            if (bus2.bus_valid) nval++;
            if (w ? bus2.bus_we : bus2.bus_re) nstb++;
            if (bus2.m_ready[m]) begin
                lat = k;
                rd  = bus2.m_rdata;
                bus2.m_req[m] = 1'b0;
            end
        end
        check({tag, " ready cycle"}, 32'(lat), 32'(exp_lat));
        check({tag, " access cycles"}, 32'(nval), 32'(exp_acc));
        check({tag, " strobes"}, 32'(nstb), 32'd1);
        check({tag, " m_rdata"}, rd, exp_rd);
        step();
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;

        bus.m_req = '0;  bus.m_we = '0;  bus.m_addr = '0;  bus.bus_rdata = '0;
        bus.m_wdata[0] = WD0; bus.m_wdata[1] = WD1;
        bus.m_wmask[0] = WM0; bus.m_wmask[1] = WM1;
        bus2.m_req = '0; bus2.m_we = '0; bus2.m_addr = '0; bus2.bus_rdata = '0;
        bus2.m_wdata[0] = WD0; bus2.m_wdata[1] = WD1;
        bus2.m_wmask[0] = WM0; bus2.m_wmask[1] = WM1;

        // Inputs applied in a cycle, registered outputs expected in the next
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,             2'b00, 2'b00, 0, 0, 0, 0, 0, 4'h0, 0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0,             2'b00, 2'b00, 0, 0, 0, 0, 0, 4'h0, 0));
        vecs.push_back(mk(1, 2'b01, 2'b00, A_RD, 0, 0,          2'b00, 2'b00, 1, 0, 1, A_RD, WD0, WM0, 0));
        vecs.push_back(mk(1, 2'b01, 2'b00, A_RD, 0, 32'h1234_5678, 2'b00, 2'b00, 1, 0, 0, A_RD, WD0, WM0, 0));
        vecs.push_back(mk(1, 2'b01, 2'b00, A_RD, 0, 32'hDEAD_BEEF, 2'b01, 2'b00, 0, 0, 0, 0, 0, 4'h0, 32'hDEAD_BEEF));
        vecs.push_back(mk(1, 2'b00, 2'b00, A_RD, 0, 0,          2'b00, 2'b00, 0, 0, 0, 0, 0, 4'h0, 32'hDEAD_BEEF));
        vecs.push_back(mk(1, 2'b10, 2'b00, 0, A_UN, 0,          2'b10, 2'b10, 0, 0, 0, 0, 0, 4'h0, 0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 0, A_UN, 0,          2'b00, 2'b00, 0, 0, 0, 0, 0, 4'h0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0,             2'b00, 2'b00, 0, 0, 0, 0, 0, 4'h0, 0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0,             2'b00, 2'b00, 0, 0, 0, 0, 0, 4'h0, 0));
        vecs.push_back(mk(1, 2'b11, 2'b11, A_LD, A_SG, 0,       2'b00, 2'b00, 1, 1, 0, A_LD, WD0, WM0, 0));
        vecs.push_back(mk(1, 2'b11, 2'b11, A_LD, A_SG, 0,       2'b01, 2'b00, 0, 0, 0, 0, 0, 4'h0, 0));
        vecs.push_back(mk(1, 2'b10, 2'b11, A_LD, A_SG, 0,       2'b00, 2'b00, 0, 0, 0, 0, 0, 4'h0, 0));
        vecs.push_back(mk(1, 2'b10, 2'b11, A_LD, A_SG, 0,       2'b00, 2'b00, 1, 1, 0, A_SG, WD1, WM1, 0));
        vecs.push_back(mk(1, 2'b10, 2'b11, A_LD, A_SG, 0,       2'b10, 2'b00, 0, 0, 0, 0, 0, 4'h0, 0));
        vecs.push_back(mk(1, 2'b00, 2'b11, A_LD, A_SG, 0,       2'b00, 2'b00, 0, 0, 0, 0, 0, 4'h0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            rstn           = v.rstn;
            bus.m_req      = v.req;
            bus.m_we       = v.we;
            bus.m_addr[0]  = v.a0;
            bus.m_addr[1]  = v.a1;
            bus.bus_rdata  = v.rd;
            step();
            check($sformatf("v%0d m_ready", i), 32'(bus.m_ready), 32'(v.e_ready));
            check($sformatf("v%0d m_err", i), 32'(bus.m_err), 32'(v.e_err));
            check($sformatf("v%0d bus_valid", i), 32'(bus.bus_valid), 32'(v.e_valid));
            check($sformatf("v%0d bus_we", i), 32'(bus.bus_we), 32'(v.e_we));
            check($sformatf("v%0d bus_re", i), 32'(bus.bus_re), 32'(v.e_re));
            check($sformatf("v%0d m_rdata", i), bus.m_rdata, v.e_rdata);
            if (v.e_valid || !v.rstn) begin
                check($sformatf("v%0d bus_addr", i), bus.bus_addr, v.e_addr);
                check($sformatf("v%0d bus_wdata", i), bus.bus_wdata, v.e_wdata);
                check($sformatf("v%0d bus_wmask", i), 32'(bus.bus_wmask), 32'(v.e_wmask));
            end
        end

        // Continuous contention: each master issues three writes back to back
        begin
            int n = 0;
            int who[6];
            int when[6];
            int done_cnt[2];
            for (int i = 0; i < 6; i++) begin
                who[i]  = -1;
                when[i] = -1;
            end
            done_cnt[0] = 0;
            done_cnt[1] = 0;
            rstn = 1'b0;
            step();
            rstn = 1'b1;
            step();
            bus.m_we      = 2'b11;
            bus.m_addr[0] = A_LD;
            bus.m_addr[1] = A_SG;
            bus.m_req     = 2'b11;
            for (int k = 1; k <= 40 && n < 6; k++) begin
                step();
                for (int m = 0; m < 2; m++) begin
                    if (bus.m_ready[m]) begin
                        if (n < 6) begin
                            who[n]  = m;
                            when[n] = k;
                            n++;
                        end
                        done_cnt[m]++;
                        if (done_cnt[m] == 3) bus.m_req[m] = 1'b0;
                    end
                end
            end
            check("contention completions", 32'(n), 32'd6);
            for (int i = 0; i < 6; i++) begin
                check($sformatf("contention #%0d master", i), 32'(who[i]), 32'(i % 2));
                check($sformatf("contention #%0d cycle", i), 32'(when[i]), 32'(2 + 3 * i));
            end
            bus.m_req = 2'b00;
            step();
        end

        // Reset in the first ACCESS cycle of a dmem read, request still held
        begin
            int          lat = 0;
            int          nre = 0;
            logic [31:0] rd = '0;
            logic        err = 1'b0;
            bus.m_we      = 2'b00;
            bus.m_addr[0] = 32'h0010_0008;
            bus.bus_rdata = 32'h5A5A_1234;
            bus.m_req     = 2'b01;
            step();
            check("rst-mid re strobe", 32'(bus.bus_re), 32'd1);
            rstn          = 1'b0;
            bus.bus_rdata = 32'hCAFE_F00D;
            step();
            check("rst-mid m_ready", 32'(bus.m_ready), 32'd0);
            check("rst-mid m_err", 32'(bus.m_err), 32'd0);
            check("rst-mid bus_valid", 32'(bus.bus_valid), 32'd0);
            check("rst-mid bus_re", 32'(bus.bus_re), 32'd0);
            check("rst-mid bus_we", 32'(bus.bus_we), 32'd0);
            check("rst-mid bus_addr", bus.bus_addr, 32'd0);
            check("rst-mid bus_wdata", bus.bus_wdata, 32'd0);
            check("rst-mid m_rdata", bus.m_rdata, 32'd0);
            rstn          = 1'b1;
            bus.bus_rdata = 32'h5A5A_1234;
            for (int k = 1; k <= 10 && lat == 0; k++) begin
                step();
                if (bus.bus_re) nre++;
                if (bus.m_ready[0]) begin
                    lat = k;
                    rd  = bus.m_rdata;
                    err = bus.m_err[0];
                    bus.m_req = 2'b00;
                end
            end
            check("rst-mid regrant ready cycle", 32'(lat), 32'd3);
            check("rst-mid regrant re strobes", 32'(nre), 32'd1);
            check("rst-mid regrant m_rdata", rd, 32'h5A5A_1234);
            check("rst-mid regrant m_err", 32'(err), 32'd0);
            step();
        end

        // DMEM_RD_LAT=2 instance: slow dmem read, fast timer read, 1-cycle write
        run2(0, 1'b0, 32'h0010_0000, "lat2 dmem read", 4, 3, 32'h103);
        run2(1, 1'b0, 32'h0030_0000, "lat2 timer read", 2, 1, 32'h101);
        run2(0, 1'b1, 32'h0010_0010, "lat2 dmem write", 2, 1, 32'h101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Two-master arbiter and access sequencer for the memory-mapped device bus. It sits between the CPU data port (master 0) and the serial boot loader (master 1) on one side, and the shared address decoder / device bus on the other. Masters are served round-robin, and each access is locked for its full duration. Per-region wait states are inserted, and accesses to unmapped regions complete with an error response.

## Interface
Parameters:
- `DMEM_RD_LAT`, default 1: extra read wait cycles for region 0x1 (synchronous data RAM).
- `IO_RD_LAT`, default 0: extra read wait cycles for all other mapped regions.

Ports (one clock; reset is synchronous and active-low):
- `clk` input 1: system clock; all state updates on the rising edge.
- `rstn` input 1: synchronous, active-low reset.
- `m_req` input [1:0]: access request per master; held until that master's `m_ready`.
- `m_we` input [1:0]: 1 = write, 0 = read.
- `m_addr` input [1:0][31:0]: byte address.
- `m_wdata` input [1:0][31:0]: write data.
- `m_wmask` input [1:0][3:0]: byte-enable mask.
- `m_ready` output [1:0]: one-cycle completion pulse.
- `m_err` output [1:0]: valid with `m_ready`; 1 = unmapped region.
- `m_rdata` output [31:0]: read data; valid with `m_ready`, held until the next completion.
- `bus_valid` output 1: the shared bus carries an active access.
- `bus_we` output 1: write strobe; exactly one cycle per write.
- `bus_re` output 1: read strobe; exactly one cycle per read, for pop-on-read devices.
- `bus_addr` output 32: forwarded address.
- `bus_wdata` output 32: forwarded write data.
- `bus_wmask` output 4: forwarded byte-enable mask.
- `bus_rdata` input 32: decoder output data.

## Operation
- Region ID is `addr[23:20]`.
  - Mapped IDs: 0x1 dmem, 0x2 seg, 0x3 timer, 0x4 cmem, 0x5 kbd, 0x6 sw, 0x7 led, 0x8 vga, 0xF serial.
  - All other IDs are unmapped.
- States: IDLE, ACCESS, RESP.
- **IDLE**
  - If any `m_req` is set, select a master.
  - Only one requester: grant it.
  - Both requesting: grant the master not served last. The `last` pointer resets to 1, so M0 wins the first tie.
  - On grant, latch `we`/`addr`/`wdata`/`wmask`, load the wait counter with the region latency, and set `last`.
  - Mapped region → ACCESS. Unmapped region → RESP with `err=1`, `rdata=0`, and no bus activity.
- **ACCESS**
  - `bus_valid=1` and `bus_addr`/`bus_wdata`/`bus_wmask` are driven from the latched values.
  - `bus_we` (writes) or `bus_re` (reads) is high only in the first ACCESS cycle.
  - Writes always take 1 ACCESS cycle, regardless of latency parameters.
  - Reads take LAT+1 ACCESS cycles.
  - In the final ACCESS cycle, `bus_rdata` is registered into `m_rdata`, then → RESP.
  - The wait counter is 2 bits wide; it saturates and never wraps.
- **RESP**
  - `m_ready[g]=1` and `m_err[g]` are driven for the granted master only, for one cycle, then → IDLE.
  - Write completions leave `m_rdata` unchanged.
- Requests arriving while the arbiter is busy wait; a request is never dropped.
- Changing or dropping `m_req` before `m_ready` is a protocol violation and its behaviour is undefined. The bench asserts that this never happens.
- Reset, including mid-ACCESS or mid-RESP, forces IDLE with no `m_ready` pulse.
  - Reset values: all outputs 0, `m_rdata=0`, `last=1`.
  - A strobe already issued is not repeated.

## Timing
- Request sampled in IDLE at cycle t.
- Write: ACCESS at t+1, `m_ready` at t+2.
- Read to region 0x1 with default parameters: ACCESS at t+1..t+2, `m_ready` at t+3.
- Read to any other mapped region: ACCESS at t+1, `m_ready` at t+2.
- Unmapped region: `m_ready` with `m_err` at t+1.
- Minimum issue interval is 3 cycles (RESP→IDLE→grant); the earliest next grant is the cycle after RESP.
- A master whose request has just completed cannot win the following tie.
- Under continuous contention both masters alternate, so neither waits more than one transaction.

## Structure
- Package `mmio_pkg`:
  - region ID `localparam`s (`ID_DMEM`=4'h1 … `ID_SERIAL`=4'hF);
  - `function is_mapped(logic [3:0])`;
  - `typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t`.
- The address decoder and this arbiter both import `mmio_pkg`.
- Sub-module `rr_pick2`: combinational 2-way round-robin selector, inputs `req[1:0]` and `last`, outputs `gnt[1:0]` (one-hot).

## Test plan
- **Single read, region 0x1:** M0 reads 0x0010_0004, bus returns 0xDEADBEEF on its second ACCESS cycle → `m_ready[0]` at t+3, `m_rdata`=0xDEADBEEF, `bus_re` high for exactly 1 cycle.
- **Tie arbitration:** M0 and M1 request simultaneously after reset, M0 writing 0x0070_0000 and M1 writing 0x0020_0000 → M0 granted first. M1 completes at t+5. `bus_we` pulses exactly twice.
- **Unmapped access:** M1 reads 0x00A0_0000 → `m_ready[1]`+`m_err[1]` at t+1, `m_rdata`=0, `bus_valid` never asserted.
- **Continuous contention:** both masters hold `req` for 6 transactions → grants alternate M0, M1, M0, …, each completion 3 cycles apart.
- **Reset mid-read:** reset asserted in the first ACCESS cycle of a dmem read → all outputs 0 the next cycle, no `m_ready`. After reset is released, the still-held request is re-granted and completes normally.
- **Latency parameter:** `DMEM_RD_LAT`=2 → dmem read has 3 ACCESS cycles and `m_ready` at t+4. Timer read (0x0030_0000) is still at t+2.
